// File: rtl/product_bcd_pkg.sv
// Shared types and constants for the product-to-BCD conversion path.
// Default widths match the 4x4 multiplier's 8-bit product.
package product_bcd_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StConvert = 2'd1,
    StDone    = 2'd2
  } state_e;

  localparam int unsigned BCD_ADJ_THRESH = 5;
  localparam int unsigned BCD_ADJ_ADD    = 3;

  localparam int unsigned IN_W_DEF   = 8;
  localparam int unsigned DIGITS_DEF = 3;

  // Elaboration-time helper for the input/digit range check.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adjust
  import product_bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'(BCD_ADJ_THRESH)) begin
      digit_o = digit_i + 4'(BCD_ADJ_ADD);
    end
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready on both sides and a registered leading-zero mask.
module product_bcd_converter
  import product_bcd_pkg::*;
#(
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_lz_mask,
  output logic                  busy
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned SrW  = BcdW + IN_W;
  localparam int unsigned CntW = $clog2(IN_W + 1);

  if (((64'd1 << IN_W) - 64'd1) > (pow10(DIGITS) - 64'd1)) begin : g_range_check
    $error("product_bcd_converter: DIGITS too small for IN_W");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SrW-1:0]    sr_q, sr_d;
  logic [SrW-1:0]    sr_adj, sr_shift;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0] lz_q, lz_d;
  logic [BcdW-1:0]   new_bcd;
  logic [DIGITS-1:0] new_lz;
  logic              zero_run;
  logic              last_shift;

  // Per-digit correction on the BCD half; the binary half passes untouched.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (sr_q[IN_W + 4*i +: 4]),
      .digit_o (sr_adj[IN_W + 4*i +: 4])
    );
  end
  assign sr_adj[IN_W-1:0] = sr_q[IN_W-1:0];
  assign sr_shift         = sr_adj << 1;

  assign last_shift = (cnt_q == CntW'(IN_W - 1));
  assign new_bcd    = sr_shift[SrW-1 -: BcdW];

  // A digit is a leading zero when it and every more significant digit is zero.
  always_comb begin
    zero_run = 1'b1;
    new_lz   = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run  = zero_run & (new_bcd[4*i +: 4] == 4'd0);
      new_lz[i] = zero_run;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (in_valid)   state_d = StConvert;
      StConvert: if (last_shift) state_d = StDone;
      StDone:    if (out_ready)  state_d = StIdle;
      default:                   state_d = StIdle;
    endcase
  end

  // Output decode, from registered state only
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  // Datapath next-state
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    lz_d  = lz_q;
    if ((state_q == StIdle) && in_valid) begin
      sr_d  = {{BcdW{1'b0}}, in_bin};
      cnt_d = '0;
    end else if (state_q == StConvert) begin
      sr_d  = sr_shift;
      cnt_d = cnt_q + CntW'(1);
      if (last_shift) begin
        bcd_d = new_bcd;
        lz_d  = new_lz;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
      lz_q  <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      bcd_q <= bcd_d;
      lz_q  <= lz_d;
    end
  end

  assign out_bcd     = bcd_q;
  assign out_lz_mask = lz_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Scoreboard bench for product_bcd_converter: expected digits come from a
// divide/modulo decimal model, compared when the DUT hands off a result.
module tb_product_bcd_converter;

  localparam int unsigned IN_W   = 8;
  localparam int unsigned DIGITS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic [2:0]  out_lz_mask;
  logic        busy;

  typedef struct packed {
    logic [11:0] bcd;
    logic [2:0]  lz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   n_sent   = 0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  product_bcd_converter #(
    .IN_W   (IN_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bin      (in_bin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bcd     (out_bcd),
    .out_lz_mask (out_lz_mask),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_model(input int v);
    exp_t e;
    e.bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    e.lz  = {(v < 100), (v < 10), 1'b0};
    return e;
  endfunction

  // Handshake happens at the next posedge; inputs are stable at negedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      n_out++;
      check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("out_bcd", 32'(out_bcd), 32'(e.bcd));
        check_eq("out_lz_mask", 32'(out_lz_mask), 32'(e.lz));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(3) != 0);
    end
  end

  task automatic send(input logic [7:0] v, input bit track);
    int c = 0;
    while (!in_ready && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_bin   = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bin   = 8'($urandom);
    if (track) begin
      sb.push_back(ref_model(int'(v)));
      n_sent++;
    end
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while ((sb.size() != 0 || busy) && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_out_bcd"}, 32'(out_bcd), 32'd0);
    check_eq({tag, "_lz"}, 32'(out_lz_mask), 32'd0);
  endtask

  initial begin
    int lat;
    int dir_vals[4] = '{225, 255, 9, 40};

    rst = 1'b1; in_valid = 1'b0; in_bin = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero input: latency and single-cycle out_valid
    send(8'd0, 1'b1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 50);
    check_eq("latency", 32'(lat), 32'(IN_W));
    @(posedge clk); #1;
    check_eq("valid_one_cycle", 32'(out_valid), 32'd0);
    check_eq("ready_after_hs", 32'(in_ready), 32'd1);
    check_eq("zero_drained", 32'(sb.size()), 32'd0);

    foreach (dir_vals[i]) begin
      send(8'(dir_vals[i]), 1'b1);
      drain("directed_drain");
    end

    // Back-pressure
    out_ready = 1'b0;
    send(8'd100, 1'b1);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (5) begin
      check_eq("bp_valid_hold", 32'(out_valid), 32'd1);
      check_eq("bp_bcd_hold", 32'(out_bcd), 32'h100);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_valid_drop", 32'(out_valid), 32'd0);
    check_eq("bp_ready_rise", 32'(in_ready), 32'd1);

    // Input offered while converting must be ignored
    send(8'd77, 1'b1);
    in_valid = 1'b1;
    in_bin   = 8'd200;
    repeat (3) begin
      check_eq("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("busy_drain");
    check_eq("busy_result", 32'(out_bcd), 32'h077);
    repeat (12) @(posedge clk);
    #1;

    // Reset at count = 4
    send(8'd123, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    in_valid = 1'b1;
    in_bin   = 8'd55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("no_capture_in_reset", 32'(busy), 32'd0);
    send(8'd123, 1'b1);
    drain("reissue_drain");
    check_eq("reissue_result", 32'(out_bcd), 32'h123);

    // Random stream with stalls
    rand_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      send(8'($urandom_range(255)), 1'b1);
      if ($urandom_range(7) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain("stream_drain");
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("out_count", 32'(n_out), 32'(n_sent));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
# product_bcd_converter

Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock) that sits directly downstream of the 4-bit sequential multiplier. It takes the 8-bit product through a valid/ready handshake, emits packed BCD digits and a leading-zero mask, and feeds the seven-segment display driver.

## Interface
- IN_W, default 8: binary input width. Must satisfy 2^IN_W − 1 ≤ 10^DIGITS − 1; the implementation checks this at elaboration.
- DIGITS, default 3: number of BCD output digits.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream presents a product on in_bin.
- in_ready  out  1  block accepts input. High only in IDLE.
- in_bin  in  IN_W  unsigned binary value. Sampled only on accept.
- out_valid  out  1  out_bcd and out_lz_mask are valid. High only in DONE.
- out_ready  in  1  downstream consumes the result.
- out_bcd  out  4*DIGITS  packed BCD. Digit i occupies bits [4i+3:4i]; digit 0 is the units digit.
- out_lz_mask  out  DIGITS  bit i set when digit i is a leading zero. Bit 0 is never set.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Internal shift register holds {bcd[4*DIGITS-1:0], bin[IN_W-1:0]}, width 4*DIGITS+IN_W. A bit counter of width clog2(IN_W+1) tracks progress.
- FSM states:
  - IDLE → CONVERT on accept (in_valid && in_ready). On accept, bin ← in_bin, bcd ← 0, count ← 0.
  - CONVERT, once per clock:
    - Every BCD digit ≥ 5 gets +3 (4-bit, no carry out).
    - The whole register then shifts left by 1, with 0 into the LSB.
    - count increments.
    - When the shift that makes count = IN_W completes, go to DONE.
  - DONE: out_valid = 1. On out_ready → IDLE. Otherwise hold.
  - Unused encodings → IDLE.
- out_bcd and out_lz_mask are registered. They update only on the CONVERT→DONE transition and stay stable while out_valid && !out_ready. Outside DONE they hold the last result (0 after reset).
- out_lz_mask is computed once at DONE entry: bit i = 1 iff digits i..DIGITS-1 are all zero, for i ≥ 1.
- in_valid during CONVERT or DONE is ignored; in_ready = 0. Changes on in_bin after accept have no effect.
- No overlap: a new input can be accepted no earlier than the cycle after the out handshake.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, out_bcd 0, out_lz_mask 0, count 0, shift register 0.
- Latency: accept at edge T → out_valid high after edge T+IN_W (8 cycles at the default). The first consuming edge is T+IN_W+1.
- Throughput: one conversion per IN_W+2 cycles with out_ready tied high (10 at the default).
- out handshake at edge E → out_valid low and in_ready high after E. The next accept is possible at E+1.
- in_ready and out_valid are pure decodes of registered state. No combinational path from in_valid or out_ready to any output.
- rst asserted mid-CONVERT or mid-DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse is produced. A value presented during reset is not captured.

## Structure
- Shared package product_bcd_pkg holds:
  - state enum (IDLE, CONVERT, DONE);
  - BCD_ADJ_THRESH = 5 and BCD_ADJ_ADD = 3;
  - the default widths IN_W_DEF = 8 and DIGITS_DEF = 3, shared with the multiplier's product width.
- One sub-module: bcd_digit_adjust. It is combinational, 4-bit in and 4-bit out, and adds 3 when the input is ≥ 5. It is instantiated DIGITS times via generate; the top holds the FSM, counter, shift register and output registers.

## Test plan
- Reset then in_bin = 0, out_ready = 1 → out_bcd = 12'h000 and out_lz_mask = 3'b110, with out_valid exactly 8 cycles after accept and for one cycle.
- in_bin = 225 (15×15, from the multiplier) → out_bcd = 12'h225, out_lz_mask = 3'b000. Likewise 255 → 12'h255, 9 → 12'h009 with mask 3'b110, and 40 → 12'h040 with mask 3'b100.
- Back-pressure: convert 100, hold out_ready = 0 for 5 cycles → out_valid stays 1 and out_bcd stays 12'h100 throughout. After out_ready = 1, in_ready rises the next cycle.
- Busy-time input: accept 77, then pulse in_valid with in_bin = 200 during CONVERT → in_ready = 0, result is 12'h077, and 200 is never converted.
- Reset mid-conversion: accept 123, assert rst at count = 4 → outputs return to reset values at once. Re-issue 123 → 12'h123 after 8 cycles.
- Back-to-back stream: 256 random values with random out_ready stalls → every result matches a reference binary-to-decimal model, with no drops or duplicates.
